// File: rtl/reg_map_restorer.sv
// rtl/reg_map_restorer.sv - logical/physical register map with identity-restore sequencer
// Optional sticky drop flag port swap_dropped_err is enabled by REG_MAP_RESTORE_ERR_EN.
module reg_map_restorer (
  input  logic       clk,
  input  logic       reset,
  input  logic       swap_valid,
  input  logic [1:0] swap_a,
  input  logic [1:0] swap_b,
  input  logic [1:0] log_q,
  output logic [1:0] log_q_phys,
  input  logic [1:0] phys_q,
  output logic [1:0] phys_q_log,
  input  logic       restore_start,
  output logic       restore_busy,
  output logic       restore_done,
  output logic       rf_swap_valid,
  output logic [1:0] rf_swap_p0,
  output logic [1:0] rf_swap_p1,
  input  logic       rf_swap_ready
`ifdef REG_MAP_RESTORE_ERR_EN
  ,
  output logic       swap_dropped_err
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;

  state_t     state, state_next;
  logic [1:0] idx, idx_next;
  logic [1:0] map_t [4];
  logic [1:0] inv_t [4];
  logic       do_swap, do_fix, load_req;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    do_swap    = 1'b0;
    do_fix     = 1'b0;
    load_req   = 1'b0;
    case (state)
      IDLE: begin
        do_swap = swap_valid && (swap_a != swap_b);
        if (restore_start) begin
          state_next = SCAN;
          idx_next   = 2'd0;
        end
      end
      SCAN: begin
        if (map_t[idx] == idx) begin
          if (idx == 2'd2) state_next = DONE;
          else             idx_next   = idx + 2'd1;
        end else begin
          state_next = ISSUE;
          load_req   = 1'b1;
        end
      end
      ISSUE: begin
        if (rf_swap_ready) begin
          do_fix = 1'b1;
          if (idx == 2'd2) begin
            state_next = DONE;
          end else begin
            state_next = SCAN;
            idx_next   = idx + 2'd1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      rf_swap_p0 <= 2'd0;
      rf_swap_p1 <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        map_t[k] <= 2'(k);
        inv_t[k] <= 2'(k);
      end
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (load_req) begin
        rf_swap_p0 <= idx;
        rf_swap_p1 <= map_t[idx];
      end
      if (do_swap) begin
        map_t[swap_a]        <= map_t[swap_b];
        map_t[swap_b]        <= map_t[swap_a];
        inv_t[map_t[swap_a]] <= swap_b;
        inv_t[map_t[swap_b]] <= swap_a;
      end
      // Exchange map entries i and inv[i]; i lands home, its old occupant moves over.
      if (do_fix) begin
        map_t[inv_t[idx]] <= map_t[idx];
        map_t[idx]        <= idx;
        inv_t[map_t[idx]] <= inv_t[idx];
        inv_t[idx]        <= idx;
      end
    end
  end

`ifdef REG_MAP_RESTORE_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset)                            swap_dropped_err <= 1'b0;
    else if (swap_valid && state != IDLE)  swap_dropped_err <= 1'b1;
  end
`endif

  // Status outputs are masked while reset is held so they read 0 during reset too.
  assign restore_busy  = reset && (state != IDLE);
  assign restore_done  = reset && (state == DONE);
  assign rf_swap_valid = reset && (state == ISSUE);
  assign log_q_phys    = map_t[log_q];
  assign phys_q_log    = inv_t[phys_q];

endmodule
